kb_code_ctrl: RTL

//  Sequences PS/2 keyboard scan bytes from the PS/2 receiver into ASCII characters for the text/Pong UI.

---
 rtl/kb_pkg.sv | 29 ++
 rtl/kb_code_ctrl_if.sv | 24 ++
 rtl/kb_code_ctrl_fifo.sv | 75 +++++++
 rtl/kb_code_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/kb_pkg.sv
// rtl/kb_pkg.sv - scan-code constants, FSM state encoding and case helper for kb_code_ctrl
package kb_pkg;

  typedef enum logic [1:0] {
    KB_IDLE    = 2'd0,
    KB_BRK     = 2'd1,
    KB_EXT     = 2'd2,
    KB_EXT_BRK = 2'd3
  } kb_state_e;

  localparam logic [7:0] SC_BRK         = 8'hF0;
  localparam logic [7:0] SC_EXT         = 8'hE0;
  localparam logic [7:0] SC_LSHIFT      = 8'h12;
  localparam logic [7:0] SC_RSHIFT      = 8'h59;
  localparam logic [7:0] SC_CAPS        = 8'h58;
  localparam logic [7:0] ASCII_UNMAPPED = 8'h2A;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

  // The lookup returns uppercase letters; lowercase unless exactly one of shift/caps is active.
  function automatic logic [7:0] kb_apply_case(input logic [7:0] ascii, input logic upper);
    logic [7:0] res;
    res = ascii;
    if ((ascii >= 8'h41) && (ascii <= 8'h5A) && !upper) begin
      res = ascii + ASCII_CASE_OFS;
    end
    return res;
  endfunction

endpackage

// File: rtl/kb_code_ctrl_if.sv
// rtl/kb_code_ctrl_if.sv - receiver, lookup and consumer signals of kb_code_ctrl
interface kb_code_ctrl_if;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic [7:0] lut_key;
  logic [7:0] lut_ascii;
  logic       rd_ascii;
  logic [7:0] ascii_data;
  logic       buf_empty;
  logic       buf_full;
  logic       overflow;
  logic       shift_on;
  logic       caps_on;

  modport master (
    output rx_done_tick, rx_data, lut_ascii, rd_ascii,
    input  lut_key, ascii_data, buf_empty, buf_full, overflow, shift_on, caps_on
  );

  modport slave (
    input  rx_done_tick, rx_data, lut_ascii, rd_ascii,
    output lut_key, ascii_data, buf_empty, buf_full, overflow, shift_on, caps_on
  );
endinterface

// File: rtl/kb_code_ctrl_fifo.sv
// rtl/kb_code_ctrl_fifo.sv - kb_fifo: 2**W_SIZE x 8 character buffer with registered full/empty flags
module kb_fifo #(
  parameter int W_SIZE = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr,
  input  logic [7:0] wdata,
  input  logic       rd,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  logic [7:0]        mem_q [2**W_SIZE];
  logic [W_SIZE-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              wr_ok, rd_ok;
  logic [W_SIZE-1:0] wptr_inc, rptr_inc;

  assign rd_ok    = rd && !empty_q;
  // A write into a full buffer still lands when a pop frees the slot in the same cycle.
  assign wr_ok    = wr && (!full_q || rd_ok);
  assign wptr_inc = wptr_q + W_SIZE'(1);
  assign rptr_inc = rptr_q + W_SIZE'(1);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    full_d  = full_q;
    empty_d = empty_q;
    case ({wr_ok, rd_ok})
      2'b10: begin
        wptr_d  = wptr_inc;
        empty_d = 1'b0;
        full_d  = (wptr_inc == rptr_q);
      end
      2'b01: begin
        rptr_d  = rptr_inc;
        full_d  = 1'b0;
        empty_d = (rptr_inc == wptr_q);
      end
      2'b11: begin
        wptr_d = wptr_inc;
        rptr_d = rptr_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/kb_code_ctrl.sv
// rtl/kb_code_ctrl.sv - PS/2 scan byte sequencer: break/extended stripping, shift/caps, case, FIFO
// Optional caps-lock tracking is enabled by defining KB_CAPSLOCK_EN.
module kb_code_ctrl
  import kb_pkg::*;
#(
  parameter int W_SIZE = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  kb_code_ctrl_if.slave kb
);

  localparam logic [1:0] ST_IDLE    = 2'(KB_IDLE);
  localparam logic [1:0] ST_BRK     = 2'(KB_BRK);
  localparam logic [1:0] ST_EXT     = 2'(KB_EXT);
  localparam logic [1:0] ST_EXT_BRK = 2'(KB_EXT_BRK);

  logic [1:0] state_q, state_d;
  logic [7:0] lut_key_q, lut_key_d;
  logic       push_req_q, push_req_d;
  logic       lshift_q, lshift_d;
  logic       rshift_q, rshift_d;
  logic       caps_q, caps_d;
  logic       overflow_q, overflow_d;

  logic       push_valid, pop_ok, drop;
  logic [7:0] push_char;
  logic       fifo_full, fifo_empty;

  always_comb begin
    state_d    = state_q;
    lut_key_d  = lut_key_q;
    push_req_d = 1'b0;
    lshift_d   = lshift_q;
    rshift_d   = rshift_q;
    caps_d     = caps_q;
    if (kb.rx_done_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (kb.rx_data == SC_BRK) begin
            state_d = ST_BRK;
          end else if (kb.rx_data == SC_EXT) begin
            state_d = ST_EXT;
          end else if (kb.rx_data == SC_LSHIFT) begin
            lshift_d = 1'b1;
          end else if (kb.rx_data == SC_RSHIFT) begin
            rshift_d = 1'b1;
`ifdef KB_CAPSLOCK_EN
          end else if (kb.rx_data == SC_CAPS) begin
            caps_d = ~caps_q;
`endif
          end else begin
            lut_key_d  = kb.rx_data;
            push_req_d = 1'b1;
          end
        end
        ST_BRK: begin
          if (kb.rx_data == SC_LSHIFT) lshift_d = 1'b0;
          if (kb.rx_data == SC_RSHIFT) rshift_d = 1'b0;
          state_d = ST_IDLE;
        end
        ST_EXT: begin
          // Extended keys have no ASCII mapping; only their break prefix needs tracking.
          state_d = (kb.rx_data == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign push_char  = kb_apply_case(kb.lut_ascii, lshift_q ^ rshift_q ^ (lshift_q & rshift_q) ^ caps_q);
  assign push_valid = push_req_q && (kb.lut_ascii != ASCII_UNMAPPED);
  assign pop_ok     = kb.rd_ascii && !fifo_empty;
  assign drop       = push_valid && fifo_full && !pop_ok;

  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (pop_ok) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      lut_key_q  <= '0;
      push_req_q <= 1'b0;
      lshift_q   <= 1'b0;
      rshift_q   <= 1'b0;
      caps_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lut_key_q  <= lut_key_d;
      push_req_q <= push_req_d;
      lshift_q   <= lshift_d;
      rshift_q   <= rshift_d;
      caps_q     <= caps_d;
      overflow_q <= overflow_d;
    end
  end

  kb_fifo #(
    .W_SIZE (W_SIZE)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr      (push_valid),
    .wdata   (push_char),
    .rd      (kb.rd_ascii),
    .rdata   (kb.ascii_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign kb.lut_key   = lut_key_q;
  assign kb.buf_empty = fifo_empty;
  assign kb.buf_full  = fifo_full;
  assign kb.overflow  = overflow_q;
  assign kb.shift_on  = lshift_q | rshift_q;
  assign kb.caps_on   = caps_q;

endmodule
